cci_mpf_shim_rd_rsp_order: RTL
==============================

CCI_MPF_SHIM_RD_RSP_ORDER -- requirements
Module: cci_mpf_shim_rd_rsp_order

Interface
REQ-001 Parameter N_SLOTS, default 16: outstanding read-request slots, indexed by tag; power of 2.
REQ-002 Parameter N_DATA_BITS, default 512: cache-line data width.
REQ-003 clk  in  1  sole clock; all state rises on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset: asserted (0) clears state immediately, deassertion is synchronous to clk.
REQ-005 rd_req_en  in  1  AFU issues a read request this cycle; the request allocates a slot.
REQ-006 rd_req_tag  in  log2(N_SLOTS)  slot tag of the request.
REQ-007 rd_req_cl_len  in  2  beats minus 1; legal values 0, 1, 3.
REQ-008 rsp_in_valid  in  1  FIU read-response beat valid; no backpressure exists.
REQ-009 rsp_in_tag  in  log2(N_SLOTS)  tag of the response beat.
REQ-010 rsp_in_cl_num  in  2  beat index within the packet; beats may arrive in any order.
REQ-011 rsp_in_data  in  N_DATA_BITS  beat data.
REQ-012 rsp_out_valid  out  1  in-order beat to AFU.
REQ-013 rsp_out_tag, rsp_out_cl_num, rsp_out_data  out  log2(N_SLOTS), 2, N_DATA_BITS  fields of the output beat.
REQ-014 rsp_out_eop  out  1  set on the last beat of a packet.
REQ-015 tag_busy  out  N_SLOTS  per-slot allocated flag.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 Storage SHALL be a data RAM of N_SLOTS*4 entries addressed {tag, cl_num}; every beat is always accepted, so no input backpressure exists.
REQ-018 Per slot SHALL hold: busy, cl_len[1:0], rcvd[3:0] bitmap, next[1:0] (next beat to emit).
REQ-019 rd_req_en on a non-busy tag SHALL set busy=1, cl_len=rd_req_cl_len, rcvd=0, next=0 at the next edge.
REQ-020 rd_req_en on a busy tag SHALL be ignored and set err.
REQ-021 A valid beat SHALL write the RAM and set rcvd[cl_num] at the same edge.
REQ-022 A beat with any of these conditions SHALL be dropped and set err: the tag is not busy; cl_num > cl_len; or rcvd[cl_num] is already set.
REQ-023 Slot eligible when busy && rcvd[next] && not already selected in the current read pipeline.
REQ-024 Arbiter SHALL select at most one eligible slot per cycle, round-robin starting after the last granted slot.
REQ-025 On grant, the arbiter SHALL issue the RAM read {tag,next} and advance next at the next edge.
REQ-026 The registered RAM output SHALL drive rsp_out_* one edge after the grant.
REQ-027 Latency SHALL be exactly 2 cycles from a beat on rsp_in (cycle t) to rsp_out_valid (cycle t+2), provided that beat is next for its slot and uncontested.
REQ-028 Beats of one tag SHALL exit with cl_num strictly 0..cl_len ascending; different tags may interleave.
REQ-029 rsp_out_eop SHALL be 1 when the emitted cl_num == cl_len.
REQ-030 On the eop grant, the slot SHALL clear busy and rcvd at the next edge.
REQ-031 tag_busy SHALL drop the cycle after the eop grant, and the tag is reusable from that cycle.
REQ-032 When rd_req_en allocates a tag in the same cycle that tag's eop is granted, the request SHALL be treated as a busy-tag request and ignored with err.
REQ-033 A beat arriving in cycle t SHALL be eligible for grant in cycle t+1.
REQ-034 Simultaneous rsp_in write and RAM read to different addresses SHALL both complete in that cycle.
REQ-035 next SHALL wrap only via slot free; no counter exceeds cl_len.
REQ-036 Sustained output SHALL be 1 beat per cycle whenever any slot is eligible.

Reset
REQ-037 reset=0 SHALL asynchronously clear the following: rsp_out_valid=0, rsp_out_eop=0, tag_busy=0, err=0, all busy/rcvd/next, and round-robin pointer=0.
REQ-038 RAM contents and rsp_out_data/tag/cl_num are not reset.
REQ-039 Reset mid-packet SHALL discard all partial packets, and no beat SHALL be emitted after reset is released until new requests arrive.

Verification
REQ-040 Req tag 3, cl_len 0; beat cl_num 0 at cycle t -> rsp_out_valid at t+2, tag 3, eop=1; tag_busy[3] low at t+2.
REQ-041 Req tag 5, cl_len 3; beats cl_num 3,1,2,0 on consecutive cycles t..t+3 -> outputs cl_num 0,1,2,3 on cycles t+5..t+8, eop only at cl_num 3.
REQ-042 Tags 1 and 2 (cl_len 1) fully received in the same window -> 4 beats on 4 consecutive cycles, round-robin interleaved, per-tag order preserved.
REQ-043 Error cases: a beat to a non-busy tag, a duplicate cl_num, or cl_num 2 with cl_len 1 -> beat dropped, err=1 sticky, no rsp_out_valid.
REQ-044 Reset low during a half-received 4-beat packet, then released -> all outputs 0, same tag re-requested and completed normally.

Source files
------------

// File: rtl/cci_mpf_shim_rd_rsp_order.sv
// Reorders out-of-order read-response beats into per-tag ascending cl_num order.
// Latency: 2 cycles from an in-order, uncontested rsp_in beat to rsp_out_valid.
// Backpressure: none; every beat is accepted, and illegal beats are dropped with a sticky err.
module cci_mpf_shim_rd_rsp_order #(
    parameter int N_SLOTS     = 16,
    parameter int N_DATA_BITS = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_req_en,
    input  logic [$clog2(N_SLOTS)-1:0] rd_req_tag,
    input  logic [1:0]                 rd_req_cl_len,
    input  logic                       rsp_in_valid,
    input  logic [$clog2(N_SLOTS)-1:0] rsp_in_tag,
    input  logic [1:0]                 rsp_in_cl_num,
    input  logic [N_DATA_BITS-1:0]     rsp_in_data,
    output logic                       rsp_out_valid,
    output logic [$clog2(N_SLOTS)-1:0] rsp_out_tag,
    output logic [1:0]                 rsp_out_cl_num,
    output logic [N_DATA_BITS-1:0]     rsp_out_data,
    output logic                       rsp_out_eop,
    output logic [N_SLOTS-1:0]         tag_busy,
    output logic                       err
);
    localparam int TW = $clog2(N_SLOTS);

    logic [N_DATA_BITS-1:0] ram [N_SLOTS*4];

    logic [N_SLOTS-1:0] busy;
    logic [1:0]         cl_len [N_SLOTS];
    logic [3:0]         rcvd   [N_SLOTS];
    logic [1:0]         nxt    [N_SLOTS];
    logic [TW-1:0]      rr_ptr;

    logic [N_SLOTS-1:0] elig;
    logic               gnt_vld;
    logic [TW-1:0]      gnt_tag;
    logic [1:0]         gnt_cl;
    logic               gnt_eop;
    logic               beat_bad;
    logic               beat_wr;

    assign tag_busy = busy;

    // next advances on grant, so a slot in the one-stage read pipeline is already past its beat
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            elig[i] = busy[i] && rcvd[i][nxt[i]];
        end
    end

    always_comb begin
        logic [TW-1:0] idx;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_tag = '0;
        for (int i = 1; i <= N_SLOTS; i++) begin
            idx = rr_ptr + TW'(i);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_tag = idx;
            end
        end
    end

    assign gnt_cl  = nxt[gnt_tag];
    assign gnt_eop = (gnt_cl == cl_len[gnt_tag]);

    assign beat_bad = !busy[rsp_in_tag]
                   || (rsp_in_cl_num > cl_len[rsp_in_tag])
                   || rcvd[rsp_in_tag][rsp_in_cl_num];
    assign beat_wr  = rsp_in_valid && !beat_bad;

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            ram[{rsp_in_tag, rsp_in_cl_num}] <= rsp_in_data;
        end
        if (gnt_vld) begin
            rsp_out_data   <= ram[{gnt_tag, gnt_cl}];
            rsp_out_tag    <= gnt_tag;
            rsp_out_cl_num <= gnt_cl;
        end
    end

    // Allocation only touches idle slots and grants only busy ones, so the updates never collide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= '0;
            rr_ptr        <= '0;
            err           <= 1'b0;
            rsp_out_valid <= 1'b0;
            rsp_out_eop   <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                cl_len[i] <= '0;
                rcvd[i]   <= '0;
                nxt[i]    <= '0;
            end
        end else begin
            if (rd_req_en) begin
                if (busy[rd_req_tag]) begin
                    err <= 1'b1;
                end else begin
                    busy[rd_req_tag]   <= 1'b1;
                    cl_len[rd_req_tag] <= rd_req_cl_len;
                    rcvd[rd_req_tag]   <= '0;
                    nxt[rd_req_tag]    <= '0;
                end
            end

            if (rsp_in_valid) begin
                if (beat_bad) begin
                    err <= 1'b1;
                end else begin
                    rcvd[rsp_in_tag][rsp_in_cl_num] <= 1'b1;
                end
            end

            if (gnt_vld) begin
                rr_ptr <= gnt_tag;
                if (gnt_eop) begin
                    busy[gnt_tag] <= 1'b0;
                    rcvd[gnt_tag] <= '0;
                    nxt[gnt_tag]  <= '0;
                end else begin
                    nxt[gnt_tag] <= gnt_cl + 2'd1;
                end
            end

            rsp_out_valid <= gnt_vld;
            rsp_out_eop   <= gnt_vld && gnt_eop;
        end
    end
endmodule
